// File: rtl/uart_tx_arbiter_if.sv
// Requester and uart_tx register-port signals between the arbiter (master) and its neighbours (slave).
// Handshake: a byte moves when req_valid[i] and req_ready[i] are both 1 in the same cycle.
// req_data/req_last stay stable while req_valid is 1, and req_ready is a one-cycle pulse.
interface uart_tx_arbiter_if;
  logic [1:0] req_valid;
  logic [7:0] req_data0;
  logic [7:0] req_data1;
  logic [1:0] req_last;
  logic [1:0] req_ready;
  logic [1:0] grant;
  logic       init_done;
  logic       cfg_err;
  logic       bus_wren;
  logic       bus_rden;
  logic [2:0] bus_addr;
  logic [7:0] bus_din;
  logic [7:0] bus_dout;

  modport master (
    input  req_valid, req_data0, req_data1, req_last, bus_dout,
    output req_ready, grant, init_done, cfg_err,
           bus_wren, bus_rden, bus_addr, bus_din
  );

  modport slave (
    output req_valid, req_data0, req_data1, req_last, bus_dout,
    input  req_ready, grant, init_done, cfg_err,
           bus_wren, bus_rden, bus_addr, bus_din
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Programs and verifies the uart_tx baud PERIOD, then shares the transmitter between two
// byte-stream requesters, round-robin per packet, polling TXFULL before every data write.
module uart_tx_arbiter #(
  parameter logic [7:0] PERIOD = 8'h0C
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.master bus,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    INIT_WR  = 3'd0,
    INIT_RD  = 3'd1,
    INIT_CHK = 3'd2,
    IDLE     = 3'd3,
    POLL     = 3'd4,
    POLL_CHK = 3'd5,
    WRITE    = 3'd6
  } state_t;

  state_t     state, state_nxt;
  logic       run;
  logic       prio, prio_nxt;
  logic [1:0] grant_nxt;
  logic       g_valid, g_last;
  logic [7:0] g_data;
  logic       wren_d, rden_d;
  logic [2:0] addr_d;
  logic [7:0] din_d;
  logic [1:0] ready_d;

  assign state_dbg = state;
  assign g_valid   = bus.grant[1] ? bus.req_valid[1] : bus.req_valid[0];
  assign g_last    = bus.grant[1] ? bus.req_last[1]  : bus.req_last[0];
  assign g_data    = bus.grant[1] ? bus.req_data1    : bus.req_data0;

  // run holds the machine in INIT_WR for the first cycle after reset so its strobes get presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT_WR;
      run       <= 1'b0;
      prio      <= 1'b0;
      bus.grant <= 2'b00;
    end else begin
      state     <= state_nxt;
      run       <= 1'b1;
      prio      <= prio_nxt;
      bus.grant <= grant_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = bus.grant;
    prio_nxt  = prio;
    if (!run) begin
      state_nxt = INIT_WR;
    end else begin
      case (state)
        INIT_WR:  state_nxt = INIT_RD;
        INIT_RD:  state_nxt = INIT_CHK;
        INIT_CHK: state_nxt = IDLE;
        IDLE: begin
          case (bus.req_valid)
            2'b01: begin grant_nxt = 2'b01; state_nxt = POLL; end
            2'b10: begin grant_nxt = 2'b10; state_nxt = POLL; end
            2'b11: begin grant_nxt = prio ? 2'b10 : 2'b01; state_nxt = POLL; end
            default: state_nxt = IDLE;
          endcase
        end
        POLL:     state_nxt = POLL_CHK;
        // A full FIFO or a mid-packet gap both go back to polling with the grant kept.
        POLL_CHK: state_nxt = (!bus.bus_dout[0] && g_valid) ? WRITE : POLL;
        WRITE: begin
          if (g_last) begin
            state_nxt = IDLE;
            grant_nxt = 2'b00;
            prio_nxt  = bus.grant[0];
          end else begin
            state_nxt = POLL;
          end
        end
        default: state_nxt = INIT_WR;
      endcase
    end
  end

  // Strobes are decoded from the upcoming state so they line up with it once registered.
  always_comb begin
    wren_d  = 1'b0;
    rden_d  = 1'b0;
    addr_d  = 3'd0;
    din_d   = 8'h00;
    ready_d = 2'b00;
    case (state_nxt)
      INIT_WR:  begin wren_d = 1'b1; din_d = PERIOD; end
      INIT_RD,
      INIT_CHK: rden_d = 1'b1;
      POLL,
      POLL_CHK: begin rden_d = 1'b1; addr_d = 3'd3; end
      WRITE: begin
        wren_d  = 1'b1;
        addr_d  = 3'd1;
        din_d   = g_data;
        ready_d = grant_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.bus_wren  <= 1'b0;
      bus.bus_rden  <= 1'b0;
      bus.bus_addr  <= 3'd0;
      bus.bus_din   <= 8'h00;
      bus.req_ready <= 2'b00;
      bus.init_done <= 1'b0;
      bus.cfg_err   <= 1'b0;
    end else begin
      bus.bus_wren  <= wren_d;
      bus.bus_rden  <= rden_d;
      bus.bus_addr  <= addr_d;
      bus.bus_din   <= din_d;
      bus.req_ready <= ready_d;
      if (run && state == INIT_CHK) begin
        bus.init_done <= 1'b1;
        if (bus.bus_dout != PERIOD) bus.cfg_err <= 1'b1;
      end
    end
  end

endmodule
